// File: rtl/ysyx_25060170_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25060170_lsu
// Description : Load/store unit between the EXU and the WBU. It accepts one op
//               at a time. Memory ops make a single-beat memory request. Store
//               data is replicated across byte lanes with a byte mask. Load
//               data is lane-extracted and zero/sign-extended. Misaligned ops
//               and memory response errors finish with out_err set.
// Ports       : clk, rst_n                  - clock, sync active-low reset
//               in_valid/in_ready, in_*     - op from EXU
//               mem_req_valid/ready, mem_*  - memory request channel
//               mem_resp_valid, mem_rdata,
//               mem_resp_err                - memory response (always taken)
//               out_valid/out_ready, out_*  - writeback payload to WBU
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25060170_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_exu_result,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_regw,
    input  logic        in_mem_rd,
    input  logic        in_mem_wr,
    input  logic [1:0]  in_size,
    input  logic        in_sext,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_regw,
    output logic        out_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic        r_wen;
    logic [4:0]  r_rd;
    logic        r_regw;
    logic        r_is_load;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [31:0] r_result;
    logic        r_out_regw;
    logic        r_err;

    logic        w_mem_op;
    logic        w_misaligned;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load_data;

    assign w_mem_op = in_mem_rd | in_mem_wr;

    // Size 3 is treated as a word, so any size with bit 1 set needs addr[1:0]==0.
    assign w_misaligned = w_mem_op &
                          (((in_size == 2'd1) & in_exu_result[0]) |
                           (in_size[1] & (|in_exu_result[1:0])));

    always_comb begin
        w_wmask = 4'b1111;
        w_wdata = in_wdata;
        case (in_size)
            2'd0: begin
                w_wmask = 4'b0001 << in_exu_result[1:0];
                w_wdata = {4{in_wdata[7:0]}};
            end
            2'd1: begin
                w_wmask = 4'b0011 << in_exu_result[1:0];
                w_wdata = {2{in_wdata[15:0]}};
            end
            default: begin
                w_wmask = 4'b1111;
                w_wdata = in_wdata;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0; word accesses are aligned so the
    // shift is zero for them.
    assign w_lane = mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = w_lane;
        case (r_size)
            2'd0:    w_load_data = {{24{r_sext & w_lane[7]}}, w_lane[7:0]};
            2'd1:    w_load_data = {{16{r_sext & w_lane[15]}}, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wmask    <= 4'd0;
            r_wen      <= 1'b0;
            r_rd       <= 5'd0;
            r_regw     <= 1'b0;
            r_is_load  <= 1'b0;
            r_size     <= 2'd0;
            r_sext     <= 1'b0;
            r_result   <= 32'd0;
            r_out_regw <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_addr    <= in_exu_result;
                        r_wdata   <= w_wdata;
                        r_rd      <= in_rd;
                        r_regw    <= in_regw;
                        r_is_load <= in_mem_rd;
                        r_size    <= in_size;
                        r_sext    <= in_sext;
                        r_result  <= in_exu_result;
                        // Write strobes only for a store that will be issued.
                        r_wen     <= in_mem_wr & ~w_misaligned;
                        r_wmask   <= (in_mem_wr & ~w_misaligned) ? w_wmask : 4'd0;
                        if (w_misaligned) begin
                            r_err      <= 1'b1;
                            r_out_regw <= 1'b0;
                            r_state    <= c_DONE;
                        end else if (w_mem_op) begin
                            r_err      <= 1'b0;
                            r_out_regw <= 1'b0;
                            r_state    <= c_REQ;
                        end else begin
                            r_err      <= 1'b0;
                            r_out_regw <= in_regw & (|in_rd);
                            r_state    <= c_DONE;
                        end
                    end
                end
                c_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_err) begin
                            r_err      <= 1'b1;
                            r_result   <= 32'd0;
                            r_out_regw <= 1'b0;
                        end else if (r_is_load) begin
                            r_result   <= w_load_data;
                            r_out_regw <= r_regw & (|r_rd);
                        end
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == c_IDLE);
    assign mem_req_valid = (r_state == c_REQ);
    assign mem_addr      = {r_addr[31:2], 2'b00};
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;
    assign out_valid     = (r_state == c_DONE);
    assign out_result    = r_result;
    assign out_rd        = r_rd;
    assign out_regw      = r_out_regw;
    assign out_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25060170_lsu
// Description : Self-checking bench for ysyx_25060170_lsu. A table of
//               directed ops is applied with hand-computed expectations,
//               followed by stall and reset-in-flight sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060170_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_exu_result;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_regw;
    logic        in_mem_rd;
    logic        in_mem_wr;
    logic [1:0]  in_size;
    logic        in_sext;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_regw;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    ysyx_25060170_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_exu_result  (in_exu_result),
        .in_wdata       (in_wdata),
        .in_rd          (in_rd),
        .in_regw        (in_regw),
        .in_mem_rd      (in_mem_rd),
        .in_mem_wr      (in_mem_wr),
        .in_size        (in_size),
        .in_sext        (in_sext),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .mem_resp_err   (mem_resp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_regw       (out_regw),
        .out_err        (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] rdata;
        logic        rerr;
        logic        exp_mem;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_result;
        logic        chk_res;
        logic        exp_regw;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic ld, input logic st, input logic [1:0] size, input logic sext,
        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
        input logic regw, input logic [31:0] rdata, input logic rerr,
        input logic exp_mem, input logic [31:0] exp_wdata, input logic [3:0] exp_wmask,
        input logic [31:0] exp_result, input logic chk_res, input logic exp_regw,
        input logic exp_err);
        vec_t v;
        v.ld = ld; v.st = st; v.size = size; v.sext = sext;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.regw = regw;
        v.rdata = rdata; v.rerr = rerr; v.exp_mem = exp_mem;
        v.exp_wdata = exp_wdata; v.exp_wmask = exp_wmask;
        v.exp_result = exp_result; v.chk_res = chk_res;
        v.exp_regw = exp_regw; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input vec_t v);
        in_exu_result = v.addr;
        in_wdata      = v.wdata;
        in_rd         = v.rd;
        in_regw       = v.regw;
        in_mem_rd     = v.ld;
        in_mem_wr     = v.st;
        in_size       = v.size;
        in_sext       = v.sext;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string n;
        n = $sformatf("vec%0d", idx);
        chk({n, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        drive_op(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (v.exp_mem) begin
            chk({n, " mem_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
            chk({n, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
            chk({n, " mem_wen"}, {31'd0, mem_wen}, {31'd0, v.st});
            chk({n, " mem_wmask"}, {28'd0, mem_wmask}, {28'd0, v.exp_wmask});
            if (v.st) chk({n, " mem_wdata"}, mem_wdata, v.exp_wdata);
            chk({n, " out_valid early"}, {31'd0, out_valid}, 32'd0);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk({n, " req dropped"}, {31'd0, mem_req_valid}, 32'd0);
            chk({n, " out_valid wait"}, {31'd0, out_valid}, 32'd0);
            mem_resp_valid = 1'b1;
            mem_rdata      = v.rdata;
            mem_resp_err   = v.rerr;
            tick();
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
        end else begin
            chk({n, " no mem_req"}, {31'd0, mem_req_valid}, 32'd0);
        end
        chk({n, " out_valid"}, {31'd0, out_valid}, 32'd1);
        if (v.chk_res) chk({n, " out_result"}, out_result, v.exp_result);
        chk({n, " out_regw"}, {31'd0, out_regw}, {31'd0, v.exp_regw});
        chk({n, " out_err"}, {31'd0, out_err}, {31'd0, v.exp_err});
        chk({n, " out_rd"}, {27'd0, out_rd}, {27'd0, v.rd});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({n, " out_valid after"}, {31'd0, out_valid}, 32'd0);
        chk({n, " in_ready after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; in_valid = 1'b0; in_exu_result = 32'd0; in_wdata = 32'd0;
        in_rd = 5'd0; in_regw = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
        in_size = 2'd0; in_sext = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_rdata = 32'd0; mem_resp_err = 1'b0;
        out_ready = 1'b0;

        //            ld st sz sx addr          wdata         rd  rw rdata         er mem exp_wdata     mask     result        cr rw er
        vecs[0]  = mk(0, 0, 2, 0, 32'h0000_1234, 32'h0,        5,  1, 32'h0,        0, 0, 32'h0,        4'h0,    32'h0000_1234, 1, 1, 0);
        vecs[1]  = mk(0, 0, 2, 0, 32'hFFFF_0000, 32'h0,        0,  1, 32'h0,        0, 0, 32'h0,        4'h0,    32'hFFFF_0000, 1, 0, 0);
        vecs[2]  = mk(1, 0, 0, 1, 32'h0000_1003, 32'h0,        3,  1, 32'h80FF_0000, 0, 1, 32'h0,       4'h0,    32'hFFFF_FF80, 1, 1, 0);
        vecs[3]  = mk(1, 0, 0, 0, 32'h0000_1003, 32'h0,        3,  1, 32'h80FF_0000, 0, 1, 32'h0,       4'h0,    32'h0000_0080, 1, 1, 0);
        vecs[4]  = mk(0, 1, 1, 0, 32'h0000_2002, 32'h0000_ABCD, 6, 1, 32'h0,        0, 1, 32'hABCD_ABCD, 4'b1100, 32'h0000_2002, 1, 0, 0);
        vecs[5]  = mk(1, 0, 2, 0, 32'h0000_3001, 32'h0,        8,  1, 32'h0,        0, 0, 32'h0,        4'h0,    32'h0,         0, 0, 1);
        vecs[6]  = mk(1, 0, 1, 1, 32'h0000_4002, 32'h0,        10, 1, 32'h8001_1234, 0, 1, 32'h0,       4'h0,    32'hFFFF_8001, 1, 1, 0);
        vecs[7]  = mk(1, 0, 1, 0, 32'h0000_4000, 32'h0,        10, 1, 32'h8001_1234, 0, 1, 32'h0,       4'h0,    32'h0000_1234, 1, 1, 0);
        vecs[8]  = mk(1, 0, 2, 0, 32'h0000_5000, 32'h0,        11, 1, 32'hDEAD_BEEF, 0, 1, 32'h0,       4'h0,    32'hDEAD_BEEF, 1, 1, 0);
        vecs[9]  = mk(0, 1, 0, 0, 32'h0000_6001, 32'h1234_56A5, 0, 0, 32'h0,        0, 1, 32'hA5A5_A5A5, 4'b0010, 32'h0000_6001, 1, 0, 0);
        vecs[10] = mk(0, 1, 2, 0, 32'h0000_7000, 32'h1122_3344, 2, 1, 32'h0,        0, 1, 32'h1122_3344, 4'b1111, 32'h0000_7000, 1, 0, 0);
        vecs[11] = mk(1, 0, 2, 0, 32'h0000_8004, 32'h0,        12, 1, 32'hDEAD_BEEF, 1, 1, 32'h0,       4'h0,    32'h0,         1, 0, 1);
        vecs[12] = mk(0, 1, 1, 0, 32'h0000_2001, 32'h0000_ABCD, 1, 0, 32'h0,        0, 0, 32'h0,        4'h0,    32'h0,         0, 0, 1);
        vecs[13] = mk(1, 0, 3, 1, 32'h0000_9008, 32'h0,        14, 1, 32'h8765_4321, 0, 1, 32'h0,       4'h0,    32'h8765_4321, 1, 1, 0);
        vecs[14] = mk(1, 0, 0, 1, 32'h0000_9000, 32'h0,        13, 1, 32'hFFFF_FF7F, 0, 1, 32'h0,       4'h0,    32'h0000_007F, 1, 1, 0);

        // Reset state
        tick();
        tick();
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_result", out_result, 32'd0);
        chk("rst out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst out_regw", {31'd0, out_regw}, 32'd0);
        chk("rst out_err", {31'd0, out_err}, 32'd0);
        chk("rst mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst mem_wmask", {28'd0, mem_wmask}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Stall: request held 5 cycles, new op offered and a stray response
        // presented while busy, then writeback held 3 cycles.
        v = mk(0, 1, 2, 0, 32'h0000_A004, 32'hCAFE_F00D, 7, 0, 32'h0, 0, 1,
               32'hCAFE_F00D, 4'b1111, 32'h0000_A004, 1, 0, 0);
        drive_op(v);
        in_valid = 1'b1;
        tick();
        in_exu_result = 32'h0000_5555; in_mem_wr = 1'b0; in_mem_rd = 1'b0;
        in_rd = 5'd9; in_regw = 1'b1; in_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d mem_req_valid", i), {31'd0, mem_req_valid}, 32'd1);
            chk($sformatf("stall%0d mem_addr", i), mem_addr, 32'h0000_A004);
            chk($sformatf("stall%0d mem_wdata", i), mem_wdata, 32'hCAFE_F00D);
            chk($sformatf("stall%0d mem_wmask", i), {28'd0, mem_wmask}, 32'hF);
            chk($sformatf("stall%0d mem_wen", i), {31'd0, mem_wen}, 32'd1);
            chk($sformatf("stall%0d in_ready", i), {31'd0, in_ready}, 32'd0);
            mem_resp_valid = (i == 2);
            mem_rdata      = 32'hFFFF_FFFF;
            tick();
        end
        mem_resp_valid = 1'b0;
        in_valid = 1'b0;
        chk("stall req still valid", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("stall wait", {31'd0, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("hold%0d out_valid", j), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d out_result", j), out_result, 32'h0000_A004);
            chk($sformatf("hold%0d out_rd", j), {27'd0, out_rd}, 32'd7);
            chk($sformatf("hold%0d out_regw", j), {31'd0, out_regw}, 32'd0);
            chk($sformatf("hold%0d out_err", j), {31'd0, out_err}, 32'd0);
            chk($sformatf("hold%0d in_ready", j), {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold done out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold done in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while waiting for a response; the late response is ignored.
        v = mk(1, 0, 2, 0, 32'h0000_B000, 32'h0, 4, 1, 32'h0, 0, 1,
               32'h0, 4'h0, 32'h0, 0, 1, 0);
        drive_op(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("rstwait in WAIT", {31'd0, mem_req_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        chk("rstwait in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstwait out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstwait mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rstwait out_result", out_result, 32'd0);
        tick();
        chk("rstwait out_valid later", {31'd0, out_valid}, 32'd0);

        run_vec(100, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_25060170_lsu.md
YSYX_25060170_LSU -- requirements
Module: ysyx_25060170_lsu

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  EXU op valid.
REQ-005 in_ready  out  1  LSU accepts op; handshake when in_valid&in_ready.
REQ-006 in_exu_result  in  32  ALU result / effective address.
REQ-007 in_wdata  in  32  store data (rs2).
REQ-008 in_rd  in  5  destination register.
REQ-009 in_regw  in  1  register write request.
REQ-010 in_mem_rd, in_mem_wr  in  1 each  load / store op; both 0 = non-memory op; both 1 never driven.
REQ-011 in_size  in  2  0=byte, 1=half, 2=word; 3 treated as word.
REQ-012 in_sext  in  1  sign-extend load data.
REQ-013 mem_req_valid  out  1; mem_req_ready  in  1  memory request handshake.
REQ-014 mem_addr  out  32  word-aligned address (addr[1:0]=0).
REQ-015 mem_wen  out  1; mem_wdata  out  32; mem_wmask  out  4  store write enable, lane-shifted data, byte mask.
REQ-016 mem_resp_valid  in  1; mem_rdata  in  32; mem_resp_err  in  1  single-beat response; always accepted.
REQ-017 out_valid  out  1; out_ready  in  1  result handshake to WBU.
REQ-018 out_result  out  32; out_rd  out  5; out_regw  out  1; out_err  out  1  writeback payload and fault flag.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-020 IDLE, accept: all inputs captured into registers; next state DONE for non-memory op, REQ for aligned load/store, DONE with error for misaligned.
REQ-021 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no memory request issued; out_err=1, out_regw=0.
REQ-022 REQ: mem_req_valid=1, payload stable until mem_req_ready; on handshake -> WAIT.
REQ-023 WAIT: on mem_resp_valid -> DONE; mem_resp_valid outside WAIT is ignored.
REQ-024 DONE: out_valid=1, payload stable until out_ready; on handshake -> IDLE.
REQ-025 Minimum latency accept->out_valid: 1 cycle non-memory/misaligned; 3 cycles memory with mem_req_ready and mem_resp_valid each asserted in the cycle after they are awaited.
REQ-026 Store mask: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; mem_wdata = in_wdata replicated across lanes (byte x4, half x2).
REQ-027 Load extract: lane selected by addr[1:0]; zero- or sign-extended to 32 bits per in_sext; word unchanged.
REQ-028 out_result: extracted load data for loads; in_exu_result for non-memory and stores.
REQ-029 out_regw: in_regw AND NOT error AND in_rd!=0; stores force out_regw=0.
REQ-030 mem_resp_err=1 on response: out_err=1, out_regw=0, out_result=0.
REQ-031 No second op accepted before the current op completes its out handshake (one op in flight).
REQ-032 Non-memory ops: mem_req_valid never asserted.

Reset
REQ-033 rst_n=0 at a rising edge: state=IDLE, all captured registers cleared; next cycle in_ready=1, mem_req_valid=0, out_valid=0, out_result=0, out_rd=0, out_regw=0, out_err=0, mem_wen=0, mem_wmask=0.
REQ-034 Reset in REQ or WAIT abandons the op; a late mem_resp_valid after reset is ignored.

Verification
REQ-035 ALU op in_exu_result=0x1234, rd=5, regw=1, out_ready=1 -> out_valid next cycle, out_result=0x1234, out_regw=1, no memory request.
REQ-036 lb addr=0x1003, mem_rdata=0x80FF_0000, sext=1 -> mem_addr=0x1000, out_result=0xFFFF_FF80; sext=0 -> 0x0000_0080.
REQ-037 sh addr=0x2002, wdata=0xABCD -> mem_wen=1, mem_wmask=4'b1100, mem_wdata=0xABCD_ABCD, out_regw=0.
REQ-038 lw addr=0x3001 -> no mem_req_valid, out_err=1, out_regw=0 after 1 cycle.
REQ-039 mem_req_ready held low 5 cycles then out_ready low 3 cycles -> mem_* and out_* payloads stable, in_ready=0 throughout.
REQ-040 rst_n low during WAIT, mem_resp_valid next cycle -> IDLE, out_valid stays 0.
